// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: round-robin sharing of one val/rdy fixed-point multiplier
// among NREQ requesters, one operation in flight at a time.
// Optional build macro FPMUL_ARB_STATS_EN adds op_count / stall_count outputs.
module fpmul_arbiter #(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned N    = 32,
  localparam int unsigned IDXW = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_val,
  output logic [NREQ-1:0]     req_rdy,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic [NREQ-1:0]     resp_val,
  input  logic [NREQ-1:0]     resp_rdy,
  output logic [N-1:0]        resp_c,
  output logic [IDXW-1:0]     grant_idx,
  output logic                mul_snd_val,
  input  logic                mul_snd_rdy,
  output logic [N-1:0]        mul_a,
  output logic [N-1:0]        mul_b,
  input  logic                mul_rcv_val,
  output logic                mul_rcv_rdy,
  input  logic [N-1:0]        mul_c
`ifdef FPMUL_ARB_STATS_EN
  ,
  output logic [31:0]         op_count,
  output logic [31:0]         stall_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [IDXW-1:0] prio;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;

  logic            found_hi;
  logic            found_lo;
  logic [IDXW-1:0] idx_hi;
  logic [IDXW-1:0] idx_lo;
  logic            sel_found;
  logic [IDXW-1:0] sel_idx;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;
  logic            accept;
  logic            resp_hs;

  assign mul_a = op_a;
  assign mul_b = op_b;

  // Round-robin pick: first valid at or above prio, else first valid below prio.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_val[i] && (IDXW'(i) >= prio) && !found_hi) begin
        found_hi = 1'b1;
        idx_hi   = IDXW'(i);
      end
      if (req_val[i] && (IDXW'(i) < prio) && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = IDXW'(i);
      end
    end
    sel_found = found_hi | found_lo;
    sel_idx   = found_hi ? idx_hi : idx_lo;
  end

  // Operand mux and one-hot accept for the selected requester, IDLE only.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    req_rdy = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDXW'(i) == sel_idx) begin
        sel_a = req_a[i*N +: N];
        sel_b = req_b[i*N +: N];
      end
      req_rdy[i] = (state == S_IDLE) && sel_found && (IDXW'(i) == sel_idx);
    end
  end

  assign accept  = (state == S_IDLE) && sel_found;
  assign resp_hs = |(resp_val & resp_rdy);

  // Control FSM with registered multiplier/response handshakes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      prio        <= '0;
      grant_idx   <= '0;
      op_a        <= '0;
      op_b        <= '0;
      resp_c      <= '0;
      resp_val    <= '0;
      mul_snd_val <= 1'b0;
      mul_rcv_rdy <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_a        <= sel_a;
            op_b        <= sel_b;
            grant_idx   <= sel_idx;
            mul_snd_val <= 1'b1;
            mul_rcv_rdy <= 1'b0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mul_snd_rdy) begin
            mul_snd_val <= 1'b0;
            mul_rcv_rdy <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mul_rcv_val) begin
            resp_c <= mul_c;
            for (int i = 0; i < int'(NREQ); i++) begin
              resp_val[i] <= (IDXW'(i) == grant_idx);
            end
            mul_rcv_rdy <= 1'b0;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_hs) begin
            resp_val    <= '0;
            prio        <= (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + IDXW'(1);
            mul_rcv_rdy <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FPMUL_ARB_STATS_EN
  // Saturating completed-operation and blocked-request counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (resp_hs && (op_count != '1)) begin
        op_count <= op_count + 32'd1;
      end
      if ((|req_val) && !(|req_rdy) && (stall_count != '1)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule
